// File: rtl/secuenciador_general.sv
// secuenciador_general: start sequencer and arbiter for NUM_CH sub-controllers.
// Picks the lowest-index pending request, issues a one-cycle one-hot start
// pulse, drives the address-mux select for that channel, waits for its done
// under a timeout watchdog, then holds the select for GAP settle cycles.
//
// Ports:
//   i_clk      system clock
//   i_reset    asynchronous, active-high reset
//   i_en       permits new transactions to start
//   i_req      per-channel start request (pulse or level)
//   i_done     per-channel completion pulse
//   i_err_clr  clears the sticky timeout flags
//   o_inicio   registered one-hot start pulse
//   o_dir_sel  registered address-mux select
//   o_busy     high whenever the sequencer is not idle
//   o_err      sticky per-channel timeout flags
//   o_ch_act   index of the current or last launched channel
module secuenciador_general #(
  parameter int unsigned             NUM_CH    = 3,
  parameter int unsigned             SEL_W     = 2,
  parameter logic [NUM_CH*SEL_W-1:0] DIR_MAP   = {2'b00, 2'b01, 2'b10},
  parameter logic [SEL_W-1:0]        IDLE_SEL  = 2'b11,
  parameter int unsigned             TIMEOUT   = 1023,
  parameter int unsigned             TO_W      = 10,
  parameter int unsigned             GAP       = 2,
  parameter bit                      AUTO_INIT = 1'b1,
  localparam int unsigned            CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [NUM_CH-1:0] i_req,
  input  logic [NUM_CH-1:0] i_done,
  input  logic              i_err_clr,
  output logic [NUM_CH-1:0] o_inicio,
  output logic [SEL_W-1:0]  o_dir_sel,
  output logic              o_busy,
  output logic [NUM_CH-1:0] o_err,
  output logic [CH_W-1:0]   o_ch_act
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  localparam int unsigned      GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TO_W-1:0]  ToLast  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GapLast = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]        r_state, w_state_d;
  logic [NUM_CH-1:0] r_inicio, w_inicio_d;
  logic [SEL_W-1:0]  r_dir_sel, w_dir_sel_d;
  logic [NUM_CH-1:0] r_err, w_err_d;
  logic [CH_W-1:0]   r_ch_act, w_ch_act_d;
  logic [NUM_CH-1:0] r_pend, w_pend_d;
  logic [TO_W-1:0]   r_to_cnt, w_to_cnt_d;
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_d;

  logic [NUM_CH-1:0] w_cand;
  logic [CH_W-1:0]   w_win;
  logic [NUM_CH-1:0] w_win_oh;
  logic              w_launch;
  logic              w_exit;

  // Fixed-priority arbitration: scanning downwards leaves the lowest set index.
  always_comb begin
    w_cand = r_pend | i_req;
    w_win  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_cand[k]) w_win = CH_W'(k);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      w_win_oh[k] = (w_win == CH_W'(k));
    end
    w_launch = (r_state == StIdle) && i_en && (|w_cand);
  end

  always_comb begin
    w_state_d   = r_state;
    w_inicio_d  = '0;
    w_dir_sel_d = r_dir_sel;
    w_ch_act_d  = r_ch_act;
    w_to_cnt_d  = r_to_cnt;
    w_gap_cnt_d = r_gap_cnt;
    w_err_d     = i_err_clr ? '0 : r_err;
    // A request seen while busy stays queued; one seen on the launch edge is absorbed.
    w_pend_d    = r_pend | i_req;
    w_exit      = 1'b0;

    case (r_state)
      StIdle: begin
        w_dir_sel_d = IDLE_SEL;
        if (w_launch) begin
          w_ch_act_d  = w_win;
          w_dir_sel_d = DIR_MAP[w_win*SEL_W +: SEL_W];
          w_inicio_d  = w_win_oh;
          w_pend_d    = w_cand & ~w_win_oh;
          w_state_d   = StStart;
        end
      end
      StStart: begin
        w_to_cnt_d = '0;
        w_state_d  = StWait;
      end
      StWait: begin
        if (i_done[r_ch_act]) begin
          w_exit = 1'b1;
        end else if (r_to_cnt == ToLast) begin
          // Set takes priority over a simultaneous err_clr.
          w_err_d[r_ch_act] = 1'b1;
          w_exit            = 1'b1;
        end else begin
          w_to_cnt_d = r_to_cnt + 1'b1;
        end
        if (w_exit) begin
          if (GAP == 0) begin
            w_state_d   = StIdle;
            w_dir_sel_d = IDLE_SEL;
          end else begin
            w_state_d   = StHold;
            w_gap_cnt_d = '0;
          end
        end
      end
      StHold: begin
        if (r_gap_cnt == GapLast) begin
          w_state_d   = StIdle;
          w_dir_sel_d = IDLE_SEL;
        end else begin
          w_gap_cnt_d = r_gap_cnt + 1'b1;
        end
      end
      default: begin
        w_state_d   = StIdle;
        w_dir_sel_d = IDLE_SEL;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_inicio  <= '0;
      r_dir_sel <= IDLE_SEL;
      r_err     <= '0;
      r_ch_act  <= '0;
      r_pend    <= NUM_CH'(AUTO_INIT);
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_inicio  <= w_inicio_d;
      r_dir_sel <= w_dir_sel_d;
      r_err     <= w_err_d;
      r_ch_act  <= w_ch_act_d;
      r_pend    <= w_pend_d;
      r_to_cnt  <= w_to_cnt_d;
      r_gap_cnt <= w_gap_cnt_d;
    end
  end

  assign o_inicio  = r_inicio;
  assign o_dir_sel = r_dir_sel;
  assign o_busy    = (r_state != StIdle);
  assign o_err     = r_err;
  assign o_ch_act  = r_ch_act;

endmodule

// File: tb/tb_secuenciador_general.sv
// Testbench for secuenciador_general: directed scenario tasks plus a randomized
// run checked against a transaction-level reference model.
module tb_secuenciador_general;

  localparam int Gap = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       err_clr;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] inicio;
  logic [1:0] dir_sel;
  logic       busy;
  logic [2:0] err;
  logic [1:0] ch_act;
  logic [10:0] obs;

  int n_vec = 0;
  int n_bad = 0;

  // Select value expected for each channel.
  logic [1:0] dir_tab [3] = '{2'b10, 2'b01, 2'b00};

  always #5 clk = ~clk;

  assign obs = {inicio, dir_sel, busy, err, ch_act};

  secuenciador_general #(
    .NUM_CH   (3),
    .SEL_W    (2),
    .DIR_MAP  (6'b00_01_10),
    .IDLE_SEL (2'b11),
    .TIMEOUT  (16),
    .TO_W     (5),
    .GAP      (Gap),
    .AUTO_INIT(1'b1)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_en     (en),
    .i_req    (req),
    .i_done   (done),
    .i_err_clr(err_clr),
    .o_inicio (inicio),
    .o_dir_sel(dir_sel),
    .o_busy   (busy),
    .o_err    (err),
    .o_ch_act (ch_act)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // obs layout: {inicio[2:0], dir_sel[1:0], busy, err[2:0], ch_act[1:0]}
  task automatic test_reset;
    logic [10:0] exp;
    rst = 1'b1; en = 1'b1; req = '0; done = '0; err_clr = 1'b0;
    tick; tick;
    exp = {3'b000, 2'b11, 1'b0, 3'b000, 2'd0};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL reset_values: got %b want %b", obs, exp); end
    rst = 1'b0;
    tick;
    exp = {3'b001, 2'b10, 1'b1, 3'b000, 2'd0};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL auto_init_launch: got %b want %b", obs, exp); end
    tick;
    exp = {3'b000, 2'b10, 1'b1, 3'b000, 2'd0};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL inicio_single_cycle: got %b want %b", obs, exp); end
    done = 3'b001; tick; done = '0;
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL hold_cycle1: got %b want %b", obs, exp); end
    tick;
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL hold_cycle2: got %b want %b", obs, exp); end
    tick;
    exp = {3'b000, 2'b11, 1'b0, 3'b000, 2'd0};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL idle_after_gap: got %b want %b", obs, exp); end
  endtask

  task automatic test_two_req;
    logic [10:0] exp;
    req = 3'b110; tick; req = '0;
    exp = {3'b010, 2'b01, 1'b1, 3'b000, 2'd1};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL arb_low_first: got %b want %b", obs, exp); end
    tick;
    done = 3'b010; tick; done = '0;
    tick; tick;
    exp = {3'b000, 2'b11, 1'b0, 3'b000, 2'd1};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL idle_between: got %b want %b", obs, exp); end
    tick;
    exp = {3'b100, 2'b00, 1'b1, 3'b000, 2'd2};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL queued_ch2: got %b want %b", obs, exp); end
    tick;
    done = 3'b100; tick; done = '0;
    tick; tick;
    exp = {3'b000, 2'b11, 1'b0, 3'b000, 2'd2};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL idle_after_ch2: got %b want %b", obs, exp); end
    tick; tick;
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL pending_empty: got %b want %b", obs, exp); end
  endtask

  task automatic test_timeout;
    logic [10:0] exp;
    req = 3'b100; tick; req = '0;
    tick;
    // Done on other channels must not end the wait.
    for (int i = 0; i < 15; i++) begin
      done = (i % 2 == 1) ? 3'b001 : 3'b010;
      tick;
    end
    done = '0;
    exp = {3'b000, 2'b00, 1'b1, 3'b000, 2'd2};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL wait_no_err_yet: got %b want %b", obs, exp); end
    tick;
    exp = {3'b000, 2'b00, 1'b1, 3'b100, 2'd2};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL timeout_err: got %b want %b", obs, exp); end
    tick; tick;
    exp = {3'b000, 2'b11, 1'b0, 3'b100, 2'd2};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL idle_after_timeout: got %b want %b", obs, exp); end
    tick; tick;
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL err_sticky: got %b want %b", obs, exp); end
    err_clr = 1'b1; tick; err_clr = 1'b0;
    exp = {3'b000, 2'b11, 1'b0, 3'b000, 2'd2};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL err_clr: got %b want %b", obs, exp); end
  endtask

  task automatic test_done_at_limit;
    logic [10:0] exp;
    req = 3'b100; tick; req = '0;
    tick;
    for (int i = 0; i < 15; i++) tick;
    done = 3'b100; tick; done = '0;
    exp = {3'b000, 2'b00, 1'b1, 3'b000, 2'd2};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL done_wins_at_limit: got %b want %b", obs, exp); end
    tick; tick;
    exp = {3'b000, 2'b11, 1'b0, 3'b000, 2'd2};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL idle_no_err: got %b want %b", obs, exp); end
  endtask

  task automatic test_en_low;
    logic [10:0] exp;
    en = 1'b0; req = 3'b010; tick; req = '0;
    tick; tick;
    exp = {3'b000, 2'b11, 1'b0, 3'b000, 2'd2};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL en_low_no_launch: got %b want %b", obs, exp); end
    en = 1'b1; tick;
    exp = {3'b010, 2'b01, 1'b1, 3'b000, 2'd1};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL en_high_launch: got %b want %b", obs, exp); end
    tick;
    done = 3'b010; tick; done = '0;
    tick; tick;
  endtask

  task automatic test_reset_mid;
    logic [10:0] exp;
    // Leave a sticky error so the asynchronous clear is observable.
    req = 3'b010; tick; req = '0;
    tick;
    for (int i = 0; i < 16; i++) tick;
    tick; tick;
    exp = {3'b000, 2'b11, 1'b0, 3'b010, 2'd1};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL err_ch1_set: got %b want %b", obs, exp); end
    req = 3'b010; tick; req = '0;
    tick; tick;
    #2 rst = 1'b1;
    #1;
    exp = {3'b000, 2'b11, 1'b0, 3'b000, 2'd0};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL async_reset: got %b want %b", obs, exp); end
    @(negedge clk);
    tick;
    rst = 1'b0;
    tick;
    exp = {3'b001, 2'b10, 1'b1, 3'b000, 2'd0};
    n_vec++;
    if (obs !== exp) begin n_bad++; $display("FAIL auto_init_after_reset: got %b want %b", obs, exp); end
    tick;
    done = 3'b001; tick; done = '0;
    tick; tick;
  endtask

  // Transaction-level model: on each launch the whole transaction length is
  // fixed from the planned done delay; t counts cycles since the start pulse.
  task automatic test_random;
    logic [10:0] exp;
    logic [2:0]  m_pend, m_err, m_oh, cand, dn;
    int          m_ch, t, w, end_t, done_at;
    bit          m_idle, m_to;
    rst = 1'b1; en = 1'b0; req = '0; done = '0; err_clr = 1'b0;
    tick;
    rst = 1'b0;
    m_pend = 3'b001; m_err = '0; m_ch = 0; m_idle = 1'b1; m_oh = '0;
    t = 0; w = 0; end_t = 0; done_at = 0; m_to = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_idle) exp = {3'b000, 2'b11, 1'b0, m_err, 2'(m_ch)};
      else        exp = {(t == 0) ? m_oh : 3'b000, dir_tab[m_ch], 1'b1, m_err, 2'(m_ch)};
      n_vec++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL random cycle %0d: got %b want %b", cyc, obs, exp);
      end
      en      = ($urandom_range(0, 7) != 0);
      req     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      err_clr = ($urandom_range(0, 15) == 0);
      dn      = 3'($urandom_range(0, 7));
      // While waiting, the active channel's done fires only at the planned cycle.
      if (!m_idle && t >= 1 && t <= w) dn[m_ch] = ((t - 1) == done_at);
      done = dn;
      @(posedge clk);
      if (m_idle) begin
        cand = m_pend | req;
        if (err_clr) m_err = '0;
        if (en && cand != 3'b000) begin
          m_ch    = cand[0] ? 0 : (cand[1] ? 1 : 2);
          m_oh    = 3'b001 << m_ch;
          m_pend  = cand & ~m_oh;
          done_at = $urandom_range(0, 19);
          m_to    = (done_at > 15);
          w       = m_to ? 16 : done_at + 1;
          end_t   = w + 1 + Gap;
          t       = 0;
          m_idle  = 1'b0;
        end else begin
          m_pend = cand;
        end
      end else begin
        m_pend = m_pend | req;
        if (err_clr) m_err = '0;
        if (m_to && t == w) m_err[m_ch] = 1'b1;
        t++;
        if (t == end_t) m_idle = 1'b1;
      end
      @(negedge clk);
    end
    done = '0; req = '0; err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; done = '0; err_clr = 1'b0;
    @(negedge clk);
    test_reset;
    test_two_req;
    test_timeout;
    test_done_at_limit;
    test_en_low;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
